// File: rtl/hazard_control_unit_if.sv
// ============================================================================
// hazard_control_unit_if
// Pipeline-side bundle of hazard inputs, control outputs and perf counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface hazard_control_unit_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) ();
  logic [REG_ADDR_WIDTH-1:0] id_reg_a_addr_in;
  logic [REG_ADDR_WIDTH-1:0] id_reg_b_addr_in;
  logic                      id_uses_reg_b_in;
  logic                      ex_mem_rd_en_in;
  logic [REG_ADDR_WIDTH-1:0] ex_reg_wr_addr_in;
  logic                      select_new_pc_in;
  logic                      mem_req_in;
  logic                      mem_ready_in;
  logic                      clr_counters_in;

  logic                      pc_stall_out;
  logic                      if_id_stall_out;
  logic                      id_ex_stall_out;
  logic                      ex_mem_stall_out;
  logic                      if_id_flush_out;
  logic                      id_ex_flush_out;
  logic                      ex_mem_flush_out;
  logic [1:0]                state_out;
  logic [CNT_WIDTH-1:0]      stall_cycles_out;
  logic [CNT_WIDTH-1:0]      flush_events_out;

  modport master (
    output id_reg_a_addr_in, id_reg_b_addr_in, id_uses_reg_b_in, ex_mem_rd_en_in,
           ex_reg_wr_addr_in, select_new_pc_in, mem_req_in, mem_ready_in,
           clr_counters_in,
    input  pc_stall_out, if_id_stall_out, id_ex_stall_out, ex_mem_stall_out,
           if_id_flush_out, id_ex_flush_out, ex_mem_flush_out, state_out,
           stall_cycles_out, flush_events_out
  );

  modport slave (
    input  id_reg_a_addr_in, id_reg_b_addr_in, id_uses_reg_b_in, ex_mem_rd_en_in,
           ex_reg_wr_addr_in, select_new_pc_in, mem_req_in, mem_ready_in,
           clr_counters_in,
    output pc_stall_out, if_id_stall_out, id_ex_stall_out, ex_mem_stall_out,
           if_id_flush_out, id_ex_flush_out, ex_mem_flush_out, state_out,
           stall_cycles_out, flush_events_out
  );
endinterface

`default_nettype wire

// File: rtl/hazard_control_unit.sv
// ============================================================================
// hazard_control_unit
// Pipeline stall/flush control: memory wait > branch flush > load-use stall.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_control_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FLUSH_CYCLES   = 1,
  parameter int CNT_WIDTH      = 16
) (
  input wire             clk,
  input wire             rst_n,
  hazard_control_unit_if.slave hcu
);

  localparam logic [1:0] c_RUN        = 2'd0;
  localparam logic [1:0] c_LOAD_STALL = 2'd1;
  localparam logic [1:0] c_FLUSH      = 2'd2;
  localparam logic [1:0] c_MEM_WAIT   = 2'd3;

  localparam logic [2:0]           c_FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX    = {CNT_WIDTH{1'b1}};

  logic [1:0]           state_q, state_d;
  logic [2:0]           flush_cnt_q, flush_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_evt_q, flush_evt_d;

  logic [REG_ADDR_WIDTH-1:0] w_ex_addr;
  logic                      w_load_use;
  logic                      w_mem_stall;
  logic                      w_branch;

  logic w_pc_stall, w_if_id_stall, w_id_ex_stall, w_ex_mem_stall;
  logic w_if_id_flush, w_id_ex_flush, w_ex_mem_flush;

  assign w_ex_addr  = hcu.ex_reg_wr_addr_in;
  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign w_load_use = hcu.ex_mem_rd_en_in && (w_ex_addr != '0) &&
                      ((w_ex_addr == hcu.id_reg_a_addr_in) ||
                       (hcu.id_uses_reg_b_in && (w_ex_addr == hcu.id_reg_b_addr_in)));

  // Once waiting, only mem_ready releases the pipe, whatever mem_req does
  assign w_mem_stall = !hcu.mem_ready_in &&
                       (hcu.mem_req_in || (state_q == c_MEM_WAIT));
  assign w_branch    = hcu.select_new_pc_in && !w_mem_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= c_RUN;
      flush_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (w_mem_stall) begin
      state_d     = c_MEM_WAIT;
      flush_cnt_d = 3'd0;
    end else if (w_branch) begin
      state_d     = c_FLUSH;
      flush_cnt_d = c_FLUSH_LOAD;
    end else begin
      case (state_q)
        c_RUN:        state_d = w_load_use ? c_LOAD_STALL : c_RUN;
        c_LOAD_STALL: state_d = c_RUN;
        c_FLUSH: begin
          flush_cnt_d = (flush_cnt_q != 3'd0) ? flush_cnt_q - 3'd1 : 3'd0;
          state_d     = (flush_cnt_q <= 3'd1) ? c_RUN : c_FLUSH;
        end
        default:      state_d = c_RUN;
      endcase
    end
  end

  always_comb begin
    w_pc_stall     = 1'b0;
    w_if_id_stall  = 1'b0;
    w_id_ex_stall  = 1'b0;
    w_ex_mem_stall = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_flush = 1'b0;
    if (rst_n) begin
      if (w_mem_stall) begin
        w_pc_stall     = 1'b1;
        w_if_id_stall  = 1'b1;
        w_id_ex_stall  = 1'b1;
        w_ex_mem_stall = 1'b1;
      end else if (w_branch) begin
        w_if_id_flush  = 1'b1;
        w_id_ex_flush  = 1'b1;
        w_ex_mem_flush = 1'b1;
      end else if ((state_q == c_RUN) && w_load_use) begin
        w_pc_stall     = 1'b1;
        w_if_id_stall  = 1'b1;
        w_id_ex_flush  = 1'b1;
      end else if (state_q == c_FLUSH) begin
        w_if_id_flush  = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_evt_d = flush_evt_q;
    if (hcu.clr_counters_in) begin
      stall_cnt_d = '0;
      flush_evt_d = '0;
    end else begin
      if (w_pc_stall && (stall_cnt_q != c_CNT_MAX))
        stall_cnt_d = stall_cnt_q + c_CNT_ONE;
      // ex_mem_flush fires exactly on cycles where a branch flush is applied
      if (w_ex_mem_flush && (flush_evt_q != c_CNT_MAX))
        flush_evt_d = flush_evt_q + c_CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_evt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_evt_q <= flush_evt_d;
    end
  end

  assign hcu.pc_stall_out     = w_pc_stall;
  assign hcu.if_id_stall_out  = w_if_id_stall;
  assign hcu.id_ex_stall_out  = w_id_ex_stall;
  assign hcu.ex_mem_stall_out = w_ex_mem_stall;
  assign hcu.if_id_flush_out  = w_if_id_flush;
  assign hcu.id_ex_flush_out  = w_id_ex_flush;
  assign hcu.ex_mem_flush_out = w_ex_mem_flush;
  assign hcu.state_out        = state_q;
  assign hcu.stall_cycles_out = stall_cnt_q;
  assign hcu.flush_events_out = flush_evt_q;

endmodule

`default_nettype wire

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter REG_ADDR_WIDTH, default 5: register address width.
REQ-002 Parameter FLUSH_CYCLES, default 1, legal 1-7: cycles if_id_flush_out is held after a taken branch/jump.
REQ-003 Parameter CNT_WIDTH, default 16: width of the performance counters.
REQ-004 Port clk  input  1: the block's only clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1: reset; synchronous and active-low.
REQ-006 Port id_reg_a_addr_in  input  REG_ADDR_WIDTH: source A register of the instruction in decode.
REQ-007 Port id_reg_b_addr_in  input  REG_ADDR_WIDTH: source B register of the instruction in decode.
REQ-008 Port id_uses_reg_b_in  input  1: decode instruction reads register B (not immediate).
REQ-009 Port ex_mem_rd_en_in  input  1: instruction in execute is a load.
REQ-010 Port ex_reg_wr_addr_in  input  REG_ADDR_WIDTH: destination register of the instruction in execute.
REQ-011 Port select_new_pc_in  input  1: taken branch/jump, from the execute pipe register output.
REQ-012 Port mem_req_in  input  1: memory stage issues a data-memory access this cycle.
REQ-013 Port mem_ready_in  input  1: data memory completes the access this cycle.
REQ-014 Port clr_counters_in  input  1: synchronous clear of both counters.
REQ-015 Outputs pc_stall_out, if_id_stall_out, id_ex_stall_out, ex_mem_stall_out  output  1 each: hold the named register.
REQ-016 Outputs if_id_flush_out, id_ex_flush_out, ex_mem_flush_out  output  1 each: load a bubble into the named register.
REQ-017 Port state_out  output  2: current FSM state (RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3).
REQ-018 Ports stall_cycles_out, flush_events_out  output  CNT_WIDTH each: performance counters.

Function
REQ-019 Control outputs shall be combinational from current state and current-cycle inputs (same-cycle effect); state and counters registered.
REQ-020 Memory wait: mem_req_in=1 and mem_ready_in=0 shall assert all four stall outputs, no flush outputs, and next state MEM_WAIT, in any state.
REQ-021 In MEM_WAIT all four stalls shall remain asserted until a cycle with mem_ready_in=1; in that cycle stalls deassert and next state is RUN, or FLUSH if select_new_pc_in=1 in that cycle.
REQ-022 Branch (no memory wait): select_new_pc_in=1 shall assert if_id_flush_out, id_ex_flush_out and ex_mem_flush_out for that cycle, override any load-use hazard, and set next state FLUSH.
REQ-023 FLUSH shall last exactly FLUSH_CYCLES cycles via a 3-bit down-counter; during it only if_id_flush_out is asserted; then RUN.
REQ-024 A new select_new_pc_in in FLUSH shall re-apply REQ-022 and reload the counter.
REQ-025 Load-use hazard: ex_mem_rd_en_in=1, ex_reg_wr_addr_in!=0, and (ex_reg_wr_addr_in==id_reg_a_addr_in or (id_uses_reg_b_in and ex_reg_wr_addr_in==id_reg_b_addr_in)).
REQ-026 In RUN, a load-use hazard with no higher-priority event shall assert pc_stall_out, if_id_stall_out and id_ex_flush_out for one cycle; next state LOAD_STALL.
REQ-027 LOAD_STALL shall last one cycle, assert no hazard outputs, and return to RUN; a hazard still present there is evaluated again under REQ-026 rules.
REQ-028 Priority: memory wait > branch flush > load-use stall.
REQ-029 Register 0 shall never cause a hazard.
REQ-030 stall_cycles_out shall increment each cycle pc_stall_out=1; flush_events_out on each cycle REQ-022 applies.
REQ-031 Counters shall saturate at all-ones, not wrap; clr_counters_in=1 zeroes both and takes priority over increment.

Reset
REQ-032 With rst_n=0 at a clock edge: state RUN, flush counter 0, both perf counters 0.
REQ-033 While rst_n=0, all stall and flush outputs shall read 0 irrespective of inputs.
REQ-034 Reset mid-MEM_WAIT or mid-FLUSH shall abort the sequence; first cycle after release behaves as RUN.

Verification
REQ-035 Load r3 in EX (rd_en=1, wr_addr=3), decode reads A=3 -> pc/if_id stall and id_ex_flush one cycle, state 1 then 0, stall_cycles=1.
REQ-036 Same with wr_addr=0 and A=0 -> no stall, state stays 0.
REQ-037 select_new_pc_in pulse, FLUSH_CYCLES=3 -> three flushes cycle 0, if_id_flush only cycles 1-3, RUN at cycle 4, flush_events=1.
REQ-038 mem_req_in=1, mem_ready_in=0 for 4 cycles then 1, concurrent load-use hazard -> all stalls 4 cycles, no id_ex_flush, stall_cycles=4.
REQ-039 Counter preset near all-ones via sustained stall -> holds at 0xFFFF; clr_counters_in -> 0 next cycle.
REQ-040 rst_n=0 during FLUSH (counter=2) -> next cycle state_out=0, all outputs 0.
